// File: rtl/windowed_regfile_if.sv
// Bundle for windowed_regfile: window-relative read/write ports, window ops,
// and the spill/fill valid-ready channels towards data memory.
interface windowed_regfile_if #(
  parameter int DATA_W    = 16,
  parameter int ARCH_REGS = 4,
  parameter int STRIDE    = 2,
  parameter int NUM_WIN   = 4
);
  localparam int P  = NUM_WIN * STRIDE;
  localparam int AW = (ARCH_REGS > 1) ? $clog2(ARCH_REGS) : 1;
  localparam int WW = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
  localparam int PW = (P > 1) ? $clog2(P) : 1;

  logic [AW-1:0]     rd_addr1;
  logic [AW-1:0]     rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              win_set_en;
  logic [WW-1:0]     win_set;
  logic              save;
  logic              restore;
  logic              busy;
  logic              spill_valid;
  logic              spill_ready;
  logic [DATA_W-1:0] spill_data;
  logic [PW-1:0]     spill_idx;
  logic              fill_valid;
  logic              fill_ready;
  logic [DATA_W-1:0] fill_data;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, win_set_en, win_set,
           save, restore, spill_ready, fill_valid, fill_data,
    input  rd_data1, rd_data2, busy, spill_valid, spill_data, spill_idx, fill_ready
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, win_set_en, win_set,
           save, restore, spill_ready, fill_valid, fill_data,
    output rd_data1, rd_data2, busy, spill_valid, spill_data, spill_idx, fill_ready
  );
endinterface

// File: rtl/windowed_regfile.sv
// Circular windowed register file with automatic spill on overflow and fill on underflow;
// combinational reads, busy stalls the core during transfers. Optional RF_BYPASS_EN forwards same-cycle writes to reads.
module windowed_regfile #(
  parameter int DATA_W    = 16,
  parameter int ARCH_REGS = 4,
  parameter int STRIDE    = 2,
  parameter int NUM_WIN   = 4
) (
  input logic                clk,
  input logic                rst,
  windowed_regfile_if.slave  bus
);
  localparam int P        = NUM_WIN * STRIDE;
  localparam int AW       = (ARCH_REGS > 1) ? $clog2(ARCH_REGS) : 1;
  localparam int WW       = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
  localparam int PW       = (P > 1) ? $clog2(P) : 1;
  localparam int SW       = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int MAX_LIVE = NUM_WIN - ARCH_REGS / STRIDE + 1;
  localparam int LW       = $clog2(MAX_LIVE + 1);

  localparam logic [LW-1:0] LIVE_MAX = LW'(MAX_LIVE);
  localparam logic [LW-1:0] LIVE_ONE = LW'(1);
  localparam logic [SW-1:0] K_LAST   = SW'(STRIDE - 1);

  typedef enum logic [1:0] {IDLE, SPILL, FILL} state_t;

  state_t            state;
  logic [WW-1:0]     cwp;
  logic [LW-1:0]     live;
  logic [SW-1:0]     k;
  logic [DATA_W-1:0] rf [P];

  logic              wr_act;
  logic [PW-1:0]     wr_ph;
  logic [DATA_W-1:0] wr_val;
  logic [PW-1:0]     rd_ph1, rd_ph2;
  logic [PW-1:0]     spill_ph0, spill_nxt;
  logic [WW-1:0]     cwp_inc, cwp_dec;

  // win may exceed NUM_WIN-1; the mod P folds it back onto the ring.
  function automatic logic [PW-1:0] phys(input int win, input int off);
    return PW'((win * STRIDE + off) % P);
  endfunction

  assign cwp_inc   = WW'((int'(cwp) + 1) % NUM_WIN);
  assign cwp_dec   = WW'((int'(cwp) + NUM_WIN - 1) % NUM_WIN);
  assign spill_ph0 = phys(int'(cwp) + 1, ARCH_REGS - STRIDE);
  assign spill_nxt = phys(int'(cwp) + 1, ARCH_REGS - STRIDE + int'(k) + 1);
  assign rd_ph1    = phys(int'(cwp), int'(bus.rd_addr1));
  assign rd_ph2    = phys(int'(cwp), int'(bus.rd_addr2));

  // Single register write port shared by core writes (IDLE) and fill beats (FILL).
  always_comb begin
    wr_act = 1'b0;
    wr_ph  = '0;
    wr_val = '0;
    if (state == IDLE && bus.wr_en) begin
      wr_act = 1'b1;
      wr_ph  = phys(int'(cwp), int'(bus.wr_addr));
      wr_val = bus.wr_data;
    end else if (state == FILL && bus.fill_valid) begin
      wr_act = 1'b1;
      wr_ph  = phys(int'(cwp) + NUM_WIN - 1, int'(k));
      wr_val = bus.fill_data;
    end
  end

`ifdef RF_BYPASS_EN
  assign bus.rd_data1 = (wr_act && wr_ph == rd_ph1) ? wr_val : rf[rd_ph1];
  assign bus.rd_data2 = (wr_act && wr_ph == rd_ph2) ? wr_val : rf[rd_ph2];
`else
  assign bus.rd_data1 = rf[rd_ph1];
  assign bus.rd_data2 = rf[rd_ph2];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < P; i++) rf[i] <= '0;
    end else if (wr_act) begin
      rf[wr_ph] <= wr_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cwp             <= '0;
      live            <= LIVE_ONE;
      k               <= '0;
      bus.busy        <= 1'b0;
      bus.spill_valid <= 1'b0;
      bus.fill_ready  <= 1'b0;
      bus.spill_data  <= '0;
      bus.spill_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.win_set_en) begin
            cwp  <= bus.win_set;
            live <= LIVE_ONE;
          end else if (bus.save && !bus.restore) begin
            if (live < LIVE_MAX) begin
              cwp  <= cwp_inc;
              live <= live + LIVE_ONE;
            end else begin
              // Registers being spilled lie outside the current window, so a
              // same-edge wr_en cannot alter the value captured here.
              state           <= SPILL;
              k               <= '0;
              bus.busy        <= 1'b1;
              bus.spill_valid <= 1'b1;
              bus.spill_idx   <= spill_ph0;
              bus.spill_data  <= rf[spill_ph0];
            end
          end else if (bus.restore && !bus.save) begin
            if (live > LIVE_ONE) begin
              cwp  <= cwp_dec;
              live <= live - LIVE_ONE;
            end else begin
              state          <= FILL;
              k              <= '0;
              bus.busy       <= 1'b1;
              bus.fill_ready <= 1'b1;
            end
          end
        end
        SPILL: begin
          if (bus.spill_valid && bus.spill_ready) begin
            if (k == K_LAST) begin
              state           <= IDLE;
              cwp             <= cwp_inc;
              bus.busy        <= 1'b0;
              bus.spill_valid <= 1'b0;
            end else begin
              k              <= k + SW'(1);
              bus.spill_idx  <= spill_nxt;
              bus.spill_data <= rf[spill_nxt];
            end
          end
        end
        FILL: begin
          if (bus.fill_valid) begin
            if (k == K_LAST) begin
              state          <= IDLE;
              cwp            <= cwp_dec;
              bus.busy       <= 1'b0;
              bus.fill_ready <= 1'b0;
            end else begin
              k <= k + SW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_windowed_regfile.sv
// Directed bench for windowed_regfile with default parameters (P=8, MAX_LIVE=3).
module tb_windowed_regfile;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  windowed_regfile_if #(.DATA_W(16), .ARCH_REGS(4), .STRIDE(2), .NUM_WIN(4)) bus ();

  windowed_regfile #(.DATA_W(16), .ARCH_REGS(4), .STRIDE(2), .NUM_WIN(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rd_addr1 = '0; bus.rd_addr2 = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.win_set_en = 1'b0; bus.win_set = '0;
    bus.save = 1'b0; bus.restore = 1'b0;
    bus.spill_ready = 1'b0; bus.fill_valid = 1'b0; bus.fill_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [15:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic read2(input logic [1:0] a1, input logic [1:0] a2);
    bus.rd_addr1 = a1; bus.rd_addr2 = a2;
    #1;
  endtask

  initial begin
    idle_inputs();
    #2;
    tick();
    rst = 1'b0;
    #1;
    check("rst_busy",        32'(bus.busy), 0);
    check("rst_spill_valid", 32'(bus.spill_valid), 0);
    check("rst_fill_ready",  32'(bus.fill_ready), 0);
    check("rst_spill_data",  32'(bus.spill_data), 0);
    check("rst_spill_idx",   32'(bus.spill_idx), 0);
    read2(2'd0, 2'd3);
    check("rst_reg0", 32'(bus.rd_data1), 0);

    // Write phys 3 at CWP 0, then a non-trapping save to CWP 1.
    write_reg(2'd3, 16'h1234);
    bus.save = 1'b1;
    tick();
    bus.save = 1'b0;
    read2(2'd1, 2'd3);
    check("save_rd_phys3", 32'(bus.rd_data1), 32'h1234);
    check("save_rd_phys5", 32'(bus.rd_data2), 0);
    check("save_busy",     32'(bus.busy), 0);

    // Overflow: phys0/1 hold known values, two saves reach live=3 at CWP 2.
    do_reset();
    write_reg(2'd0, 16'h1111);
    write_reg(2'd1, 16'h2222);
    bus.save = 1'b1;
    tick();
    tick();
    check("live_max_busy", 32'(bus.busy), 0);
    tick();
    bus.save = 1'b0;
    #1;
    check("spill_busy",   32'(bus.busy), 1);
    check("spill_valid0", 32'(bus.spill_valid), 1);
    check("spill_idx0",   32'(bus.spill_idx), 0);
    check("spill_data0",  32'(bus.spill_data), 32'h1111);
    tick();
    check("spill_hold_idx",  32'(bus.spill_idx), 0);
    check("spill_hold_data", 32'(bus.spill_data), 32'h1111);
    bus.spill_ready = 1'b1;
    tick();
    bus.spill_ready = 1'b0;
    #1;
    check("spill_idx1",   32'(bus.spill_idx), 1);
    check("spill_data1",  32'(bus.spill_data), 32'h2222);
    check("spill_busy1",  32'(bus.busy), 1);
    tick();
    check("spill_hold1",  32'(bus.spill_idx), 1);
    check("spill_valid1", 32'(bus.spill_valid), 1);
    bus.spill_ready = 1'b1;
    tick();
    bus.spill_ready = 1'b0;
    #1;
    check("spill_done_busy",  32'(bus.busy), 0);
    check("spill_done_valid", 32'(bus.spill_valid), 0);
    read2(2'd2, 2'd3);
    check("cwp3_phys0", 32'(bus.rd_data1), 32'h1111);
    check("cwp3_phys1", 32'(bus.rd_data2), 32'h2222);

    // live stays at max: another save spills phys 2,3; reset during beat 2.
    bus.save = 1'b1;
    tick();
    bus.save = 1'b0;
    #1;
    check("respill_idx0", 32'(bus.spill_idx), 2);
    bus.spill_ready = 1'b1;
    tick();
    check("respill_idx1", 32'(bus.spill_idx), 3);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy",  32'(bus.busy), 0);
    check("abort_valid", 32'(bus.spill_valid), 0);
    check("abort_idx",   32'(bus.spill_idx), 0);
    check("abort_data",  32'(bus.spill_data), 0);
    idle_inputs();
    tick();
    rst = 1'b0;
    #1;
    write_reg(2'd0, 16'h7777);
    bus.win_set_en = 1'b1; bus.win_set = 2'd0;
    tick();
    bus.win_set_en = 1'b0;
    read2(2'd0, 2'd1);
    check("abort_cwp0", 32'(bus.rd_data1), 32'h7777);

    // Underflow at live=1: fill phys 6,7.
    do_reset();
    bus.restore = 1'b1;
    tick();
    bus.restore = 1'b0;
    #1;
    check("fill_busy",  32'(bus.busy), 1);
    check("fill_ready", 32'(bus.fill_ready), 1);
    tick();
    check("fill_wait_busy", 32'(bus.busy), 1);
    bus.fill_valid = 1'b1; bus.fill_data = 16'hAAAA;
    tick();
    bus.fill_data = 16'hBBBB;
    tick();
    bus.fill_valid = 1'b0;
    #1;
    check("fill_done_busy",  32'(bus.busy), 0);
    check("fill_done_ready", 32'(bus.fill_ready), 0);
    read2(2'd0, 2'd1);
    check("fill_phys6", 32'(bus.rd_data1), 32'hAAAA);
    check("fill_phys7", 32'(bus.rd_data2), 32'hBBBB);

    // live remains 1: next restore fills phys 4,5 and lands at CWP 2.
    bus.restore = 1'b1;
    tick();
    bus.restore = 1'b0;
    #1;
    check("refill_busy", 32'(bus.busy), 1);
    bus.fill_valid = 1'b1; bus.fill_data = 16'h0C0C;
    tick();
    bus.fill_data = 16'h0D0D;
    tick();
    bus.fill_valid = 1'b0;
    read2(2'd0, 2'd2);
    check("refill_phys4", 32'(bus.rd_data1), 32'h0C0C);
    check("refill_phys6", 32'(bus.rd_data2), 32'hAAAA);

    // save+restore together is a no-op.
    bus.save = 1'b1; bus.restore = 1'b1;
    tick();
    bus.save = 1'b0; bus.restore = 1'b0;
    read2(2'd1, 2'd3);
    check("noop_busy",   32'(bus.busy), 0);
    check("noop_phys5",  32'(bus.rd_data1), 32'h0D0D);
    check("noop_phys7",  32'(bus.rd_data2), 32'hBBBB);

    // win_set_en beats save: CWP 1 with live 1, so a restore must trap.
    bus.win_set_en = 1'b1; bus.win_set = 2'd1; bus.save = 1'b1;
    tick();
    bus.win_set_en = 1'b0; bus.save = 1'b0;
    read2(2'd2, 2'd3);
    check("winset_phys4", 32'(bus.rd_data1), 32'h0C0C);
    check("winset_phys5", 32'(bus.rd_data2), 32'h0D0D);
    bus.restore = 1'b1;
    tick();
    bus.restore = 1'b0;
    #1;
    check("winset_live1", 32'(bus.busy), 1);

    // Same-cycle write/read visibility.
    do_reset();
    bus.wr_en = 1'b1; bus.wr_addr = 2'd2; bus.wr_data = 16'h5A5A;
    read2(2'd2, 2'd0);
`ifdef RF_BYPASS_EN
    check("same_cycle_rd", 32'(bus.rd_data1), 32'h5A5A);
`else
    check("same_cycle_rd", 32'(bus.rd_data1), 0);
`endif
    tick();
    bus.wr_en = 1'b0;
    #1;
    check("next_cycle_rd", 32'(bus.rd_data1), 32'h5A5A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
